kmer_match_fsm: RTL and testbench
=================================

# kmer_match_fsm

Parametrised Moore state machine that scans a stream of 2-bit nucleotides (A=0, C=1, G=2, T=3) for a programmable K-base pattern. It reports every match, including overlapping ones, with its stream position over a valid/ready handshake, and keeps a saturating match count. It sits in the genomics FPGA datapath between the base unpacker and the result collector, and generalises the fixed 3-state sequencer with configurable pattern length, counter width and flow control.

## Interface
- K, 8: pattern length in bases (2..32)
- CNT_W, 16: width of position and match counters
- clk  in  1  clock
- reset  in  1  reset: asynchronous, active-high
- cfg_pattern  in  2K  pattern; [2K-1:2K-2] = first base, [1:0] = last base
- cfg_load  in  1  start scan (sampled in IDLE only)
- cfg_stop  in  1  abort to IDLE (any state)
- in_valid  in  1  base available
- in_base  in  2  base
- in_ready  out  1  base accepted when in_valid & in_ready
- match_valid  out  1  match report pending
- match_ready  in  1  collector accepts report
- match_pos  out  CNT_W  stream index of the last base of the match
- match_count  out  CNT_W  total matches since load, saturating
- state_out  out  2  IDLE=01, SCAN=10, MATCH=11

## Operation
- States: IDLE, SCAN, MATCH. Encoding 00 is illegal and returns to IDLE on the next clock.
- IDLE, cfg_load=1:
  - latch cfg_pattern;
  - clear history shift register, fill counter, position counter and match_count;
  - go to SCAN.
- SCAN: in_ready=1. An accepted base shifts into history[1:0], with older bases moving up. The position counter increments, wrapping modulo 2^CNT_W. The fill counter saturates at K.
- Match condition, evaluated on the accepted base: fill ≥ K-1 before the accept, and the new window equals the pattern. On a match:
  - match_pos ← index of the accepted base;
  - match_count increments unless it is all-ones;
  - go to MATCH.
- MATCH: match_valid=1, in_ready=0, match_pos stable. On match_ready=1, return to SCAN. Otherwise stay in MATCH for any number of cycles.
- Matches may overlap; the history register is not cleared after a match.
- cfg_stop=1 → IDLE next cycle from any state, and a pending match is dropped. match_count and match_pos hold their last values.
- cfg_load and cfg_stop asserted together in IDLE: cfg_stop wins and the block stays in IDLE.
- cfg_load outside IDLE is ignored.

## Timing
- Reset values: state IDLE, state_out=01, in_ready=0, match_valid=0, match_pos=0, match_count=0, history/fill/position counters 0.
- Reset is asynchronous. Asserting it mid-SCAN or mid-MATCH discards pending state immediately.
- in_ready and match_valid are decoded from the registered state only.
- Latency: a matching base accepted at cycle n gives match_valid=1 at cycle n+1.
- Earliest next accept after a match is cycle n+2 (match_ready=1 at n+1).
- No input is accepted while a report is pending.
- Peak throughput is one base per cycle between matches.

## Configuration
- KMER_MASK_EN defined:
  - adds port cfg_mask (in, K bits), latched with cfg_pattern;
  - cfg_mask[i]=1 makes base i a don't-care;
  - bit ordering matches cfg_pattern (bit K-1 = first base).
- KMER_MASK_EN undefined: no cfg_mask port; every base must match exactly.

## Test plan
- K=4, pattern 8'h1B (ACGT), load, stream A,C,G,T → match_valid at the cycle after T, match_pos=3, match_count=1, state_out=11.
- K=4, pattern 8'h00 (AAAA), stream of 6 A's with match_ready=1 → three matches at match_pos 3, 4, 5; match_count=3; in_ready low one cycle per match.
- Match pending, match_ready held 0 for 5 cycles with in_valid=1 → match_valid stays 1, in_ready=0, match_pos unchanged, and no base is consumed until the handshake completes.
- CNT_W=4, pattern AAAA, 25 A's → match_pos wraps 15→0; match_count saturates at 15.
- reset asserted in MATCH → same cycle: match_valid=0, state_out=01, match_count=0; cfg_stop in MATCH → IDLE next cycle, and match_count keeps its value.
- KMER_MASK_EN, pattern ACGT, cfg_mask=4'b0100 → stream A,G,G,T matches (match_pos=3); stream A,C,G,A does not.

Source files
------------

// File: rtl/kmer_match_fsm.sv
// Streaming K-mer matcher: scans 2-bit bases for a programmable pattern and reports overlapping hits.
// Optional don't-care mask per base is enabled by defining KMER_MASK_EN.
module kmer_match_fsm #(
  parameter int K     = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2*K-1:0]   cfg_pattern,
`ifdef KMER_MASK_EN
  input  logic [K-1:0]     cfg_mask,
`endif
  input  logic             cfg_load,
  input  logic             cfg_stop,
  input  logic             in_valid,
  input  logic [1:0]       in_base,
  output logic             in_ready,
  output logic             match_valid,
  input  logic             match_ready,
  output logic [CNT_W-1:0] match_pos,
  output logic [CNT_W-1:0] match_count,
  output logic [1:0]       state_out
);

  localparam int FW = $clog2(K + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b01,
    SCAN  = 2'b10,
    MATCH = 2'b11
  } state_t;

  state_t             state;
  logic [2*K-1:0]     pattern_q;
  logic [2*K-1:0]     history;
  logic [FW-1:0]      fill;
  logic [CNT_W-1:0]   pos_cnt;
  logic [2*K-1:0]     window;
  logic [2*K-1:0]     care;
  logic               hit;

`ifdef KMER_MASK_EN
  logic [K-1:0]       mask_q;

  // Each mask bit blanks out both bits of its base in the comparison.
  always_comb begin
    care = '1;
    for (int i = 0; i < K; i++) begin
      care[2*i +: 2] = {2{~mask_q[i]}};
    end
  end
`else
  assign care = '1;
`endif

  assign window = {history[2*K-3:0], in_base};
  assign hit    = (fill >= FW'(K - 1)) && (((window ^ pattern_q) & care) == '0);

  assign state_out   = state;
  assign in_ready    = (state == SCAN);
  assign match_valid = (state == MATCH);

  // Main sequencer; cfg_stop takes priority over every other transition.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pattern_q   <= '0;
`ifdef KMER_MASK_EN
      mask_q      <= '0;
`endif
      history     <= '0;
      fill        <= '0;
      pos_cnt     <= '0;
      match_pos   <= '0;
      match_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_stop) begin
            state <= IDLE;
          end else if (cfg_load) begin
            pattern_q   <= cfg_pattern;
`ifdef KMER_MASK_EN
            mask_q      <= cfg_mask;
`endif
            history     <= '0;
            fill        <= '0;
            pos_cnt     <= '0;
            match_count <= '0;
            state       <= SCAN;
          end
        end
        SCAN: begin
          if (cfg_stop) begin
            state <= IDLE;
          end else if (in_valid) begin
            history <= window;
            pos_cnt <= pos_cnt + CNT_W'(1);
            if (fill != FW'(K)) begin
              fill <= fill + FW'(1);
            end
            if (hit) begin
              match_pos <= pos_cnt;
              if (match_count != '1) begin
                match_count <= match_count + CNT_W'(1);
              end
              state <= MATCH;
            end
          end
        end
        MATCH: begin
          if (cfg_stop) begin
            state <= IDLE;
          end else if (match_ready) begin
            state <= SCAN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kmer_match_fsm.sv
// Self-checking bench for kmer_match_fsm (K=4, CNT_W=4) against a queue-based reference model.
// Exercises the mask path too when KMER_MASK_EN is defined.
module tb_kmer_match_fsm;

  localparam int K  = 4;
  localparam int CW = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [2*K-1:0]  cfg_pattern;
  logic [K-1:0]    cfg_mask;
  logic            cfg_load, cfg_stop;
  logic            in_valid;
  logic [1:0]      in_base;
  logic            in_ready, match_valid, match_ready;
  logic [CW-1:0]   match_pos, match_count;
  logic [1:0]      state_out;

  int checks = 0;
  int failures = 0;

  kmer_match_fsm #(.K(K), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .cfg_pattern(cfg_pattern),
`ifdef KMER_MASK_EN
    .cfg_mask(cfg_mask),
`endif
    .cfg_load(cfg_load), .cfg_stop(cfg_stop), .in_valid(in_valid), .in_base(in_base),
    .in_ready(in_ready), .match_valid(match_valid), .match_ready(match_ready),
    .match_pos(match_pos), .match_count(match_count), .state_out(state_out)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0=idle, 1=scan, 2=report pending; window kept as a queue of bases.
  int             m_phase;
  logic [1:0]     m_q[$];
  logic [2*K-1:0] m_pat;
  logic [K-1:0]   m_mask;
  int             m_next_idx, m_pos, m_count, m_accepts;

  function automatic bit windowHits();
    if (m_q.size() != K) return 1'b0;
    for (int i = 0; i < K; i++) begin
      if (!m_mask[K-1-i] && (m_q[i] != m_pat[2*(K-1-i) +: 2])) return 1'b0;
    end
    return 1'b1;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase = 0; m_q.delete(); m_pat = '0; m_mask = '0;
      m_next_idx = 0; m_pos = 0; m_count = 0;
    end else begin
      case (m_phase)
        0: if (!cfg_stop && cfg_load) begin
          m_pat = cfg_pattern;
`ifdef KMER_MASK_EN
          m_mask = cfg_mask;
`else
          m_mask = '0;
`endif
          m_q.delete(); m_next_idx = 0; m_count = 0; m_phase = 1;
        end
        1: if (cfg_stop) m_phase = 0;
           else if (in_valid) begin
             m_accepts++;
             m_q.push_back(in_base);
             if (m_q.size() > K) void'(m_q.pop_front());
             if (windowHits()) begin
               m_pos = m_next_idx;
               if (m_count < (1 << CW) - 1) m_count++;
               m_phase = 2;
             end
             m_next_idx = (m_next_idx + 1) % (1 << CW);
           end
        default: if (cfg_stop) m_phase = 0;
                 else if (match_ready) m_phase = 1;
      endcase
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset) begin
      checkOutput("state_out", state_out, (m_phase == 0) ? 1 : (m_phase == 1) ? 2 : 3);
      checkOutput("in_ready", in_ready, m_phase == 1);
      checkOutput("match_valid", match_valid, m_phase == 2);
      checkOutput("match_pos", match_pos, m_pos);
      checkOutput("match_count", match_count, m_count);
    end
  end

  task automatic applyStimulus(input logic v, input logic [1:0] b, input logic r,
                               input logic ld, input logic st);
    in_valid = v; in_base = b; match_ready = r; cfg_load = ld; cfg_stop = st;
    @(negedge clk);
  endtask

  task automatic sendBase(input logic [1:0] b, input logic r);
    int target = m_accepts + 1;
    int budget = 50;
    in_valid = 1'b1; in_base = b; match_ready = r; cfg_load = 1'b0; cfg_stop = 1'b0;
    do begin
      @(negedge clk);
      budget--;
    end while (m_accepts < target && budget > 0);
    if (m_accepts < target) checkOutput("accept_timeout", m_accepts, target);
    in_valid = 1'b0;
  endtask

  task automatic loadPattern(input logic [2*K-1:0] p, input logic [K-1:0] m);
    cfg_pattern = p; cfg_mask = m;
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    m_accepts = 0;
    reset = 1'b1; cfg_pattern = '0; cfg_mask = '0; cfg_load = 0; cfg_stop = 0;
    in_valid = 0; in_base = 0; match_ready = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_state", state_out, 1);
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_match_valid", match_valid, 0);
    checkOutput("rst_count", match_count, 0);

    // ACGT single match, then a stalled report.
    loadPattern(8'h1B, 4'b0000);
    sendBase(2'd0, 1'b0); sendBase(2'd1, 1'b0); sendBase(2'd2, 1'b0); sendBase(2'd3, 1'b0);
    checkOutput("acgt_valid", match_valid, 1);
    checkOutput("acgt_pos", match_pos, 3);
    checkOutput("acgt_count", match_count, 1);
    checkOutput("acgt_state", state_out, 3);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
      checkOutput("stall_valid", match_valid, 1);
      checkOutput("stall_ready", in_ready, 0);
      checkOutput("stall_pos", match_pos, 3);
    end
    applyStimulus(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("release_state", state_out, 2);

    // Overlapping AAAA matches.
    loadPattern(8'h00, 4'b0000);
    for (int i = 0; i < 6; i++) sendBase(2'd0, 1'b1);
    applyStimulus(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("aaaa_count", match_count, 3);
    checkOutput("aaaa_pos", match_pos, 5);

    // Stop while a report is pending keeps the counters.
    sendBase(2'd0, 1'b0);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    checkOutput("stop_state", state_out, 1);
    checkOutput("stop_count", match_count, 4);
    checkOutput("stop_pos", match_pos, 6);

    // Position wrap and count saturation.
    loadPattern(8'h00, 4'b0000);
    for (int i = 0; i < 25; i++) sendBase(2'd0, 1'b1);
    applyStimulus(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("sat_count", match_count, 15);
    checkOutput("wrap_pos", match_pos, 8);

    // Asynchronous reset in the middle of a report.
    loadPattern(8'h00, 4'b0000);
    for (int i = 0; i < 4; i++) sendBase(2'd0, 1'b0);
    #1 reset = 1'b1;
    #1;
    checkOutput("areset_valid", match_valid, 0);
    checkOutput("areset_state", state_out, 1);
    checkOutput("areset_count", match_count, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

`ifdef KMER_MASK_EN
    loadPattern(8'h1B, 4'b0100);
    sendBase(2'd0, 1'b0); sendBase(2'd2, 1'b0); sendBase(2'd2, 1'b0); sendBase(2'd3, 1'b0);
    checkOutput("mask_hit", match_valid, 1);
    checkOutput("mask_pos", match_pos, 3);
    loadPattern(8'h1B, 4'b0100);
    sendBase(2'd0, 1'b1); sendBase(2'd1, 1'b1); sendBase(2'd2, 1'b1); sendBase(2'd0, 1'b1);
    checkOutput("mask_miss", match_valid, 0);
`endif

    // Randomised traffic with a reduced alphabet so matches are frequent.
    for (int c = 0; c < 1500; c++) begin
      logic [2*K-1:0] p;
      for (int j = 0; j < K; j++) p[2*j +: 2] = 2'($urandom_range(0, 1));
      cfg_pattern = p;
      cfg_mask = ($urandom_range(0, 3) == 0) ? K'($urandom) : '0;
      applyStimulus($urandom_range(0, 3) != 0,
                    ($urandom_range(0, 9) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1)),
                    $urandom_range(0, 1) == 1,
                    $urandom_range(0, 7) == 0,
                    $urandom_range(0, 63) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
